// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Decode-stage immediate generator for an RV32IM pipeline. It extracts and
//   extends the immediate selected by select_i, adds it to the instruction's
//   PC, and registers both results behind a valid/ready handshake with a
//   two-entry skid buffer. Because of the skid buffer, in_ready_o is a pure
//   register output.
//
// Parameters
//   XLEN       width of pc_i, out_o, target_o (32 or 64)
//   SEL_WIDTH  width of select_i; encodings above 3'b110 produce zero
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   in_valid_i     upstream offers an instruction
//   in_ready_o     stage can accept (skid slot free)
//   instruction_i  raw 32-bit instruction word
//   pc_i           address of instruction_i
//   select_i       immediate format: U,J,I,B,S,SHAMT,ZIMM,zero
//   flush_i        synchronous kill of every held entry
//   out_valid_o    out_o/target_o hold a valid entry
//   out_ready_i    downstream takes the entry this cycle
//   out_o          extended immediate
//   target_o       pc + immediate, modulo 2^XLEN
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int SEL_WIDTH = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instruction_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [SEL_WIDTH-1:0] select_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      out_o,
  output logic [XLEN-1:0]      target_o
);

  localparam logic [SEL_WIDTH-1:0] SEL_U     = SEL_WIDTH'(0);
  localparam logic [SEL_WIDTH-1:0] SEL_J     = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_I     = SEL_WIDTH'(2);
  localparam logic [SEL_WIDTH-1:0] SEL_B     = SEL_WIDTH'(3);
  localparam logic [SEL_WIDTH-1:0] SEL_S     = SEL_WIDTH'(4);
  localparam logic [SEL_WIDTH-1:0] SEL_SHAMT = SEL_WIDTH'(5);
  localparam logic [SEL_WIDTH-1:0] SEL_ZIMM  = SEL_WIDTH'(6);

  // Occupancy of the buffer: EMPTY (nothing held), ONE (main only),
  // FULL (main and skid).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  buf_state_e      state_q, state_d;
  logic [XLEN-1:0] mainImm_q, mainImm_d;
  logic [XLEN-1:0] mainTgt_q, mainTgt_d;
  logic [XLEN-1:0] skidImm_q, skidImm_d;
  logic [XLEN-1:0] skidTgt_q, skidTgt_d;

  logic [31:0]     imm32;
  logic [XLEN-1:0] immExt;
  logic [XLEN-1:0] tgtNew;
  logic            accept;
  logic            transfer;
  logic            unused_opcode;

  // The opcode field never contributes to any immediate.
  assign unused_opcode = ^instruction_i[6:0];

  // Every format is first assembled as a 32-bit value whose bit 31 is the
  // extension bit; the zero-extended forms have bit 31 clear, so a single
  // sign extension to XLEN covers all of them.
  always_comb begin
    imm32 = 32'd0;
    case (select_i)
      SEL_U:     imm32 = {instruction_i[31:12], 12'd0};
      SEL_J:     imm32 = {{12{instruction_i[31]}}, instruction_i[19:12],
                          instruction_i[20], instruction_i[30:21], 1'b0};
      SEL_I:     imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
      SEL_B:     imm32 = {{20{instruction_i[31]}}, instruction_i[7],
                          instruction_i[30:25], instruction_i[11:8], 1'b0};
      SEL_S:     imm32 = {{20{instruction_i[31]}}, instruction_i[31:25],
                          instruction_i[11:7]};
      SEL_SHAMT: begin
        if (XLEN == 64) imm32 = {26'd0, instruction_i[25:20]};
        else            imm32 = {27'd0, instruction_i[24:20]};
      end
      SEL_ZIMM:  imm32 = {27'd0, instruction_i[19:15]};
      default:   imm32 = 32'd0;
    endcase
  end

  assign immExt = XLEN'($signed(imm32));
  assign tgtNew = pc_i + immExt;

  // Ready depends only on state, so there is no path from out_ready_i.
  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign out_o       = mainImm_q;
  assign target_o    = mainTgt_q;

  assign accept   = in_valid_i & in_ready_o & ~flush_i;
  assign transfer = out_valid_o & out_ready_i;

  // Next-state and datapath steering for the two-slot buffer. Main always
  // drives the outputs; skid only fills when main is stalled.
  always_comb begin
    state_d   = state_q;
    mainImm_d = mainImm_q;
    mainTgt_d = mainTgt_q;
    skidImm_d = skidImm_q;
    skidTgt_d = skidTgt_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            mainImm_d = immExt;
            mainTgt_d = tgtNew;
          end
        end
        ONE: begin
          if (accept && transfer) begin
            mainImm_d = immExt;
            mainTgt_d = tgtNew;
          end else if (accept) begin
            state_d   = FULL;
            skidImm_d = immExt;
            skidTgt_d = tgtNew;
          end else if (transfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (transfer) begin
            state_d   = ONE;
            mainImm_d = skidImm_q;
            mainTgt_d = skidTgt_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and data registers; reset clears outputs to zero immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= EMPTY;
      mainImm_q <= '0;
      mainTgt_q <= '0;
      skidImm_q <= '0;
      skidTgt_q <= '0;
    end else begin
      state_q   <= state_d;
      mainImm_q <= mainImm_d;
      mainTgt_q <= mainTgt_d;
      skidImm_q <= skidImm_d;
      skidTgt_q <= skidTgt_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: a table of instruction vectors with
// constant expected immediates/targets, driven through a scoreboard queue,
// plus hand sequences for backpressure, flush, reset and XLEN=64.
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] pc;
    logic [31:0] expImm;
    logic [31:0] expTgt;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] tgt;
  } exp_t;

  localparam int NVEC = 10;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [63:0] pc64;
  logic [2:0]  sel;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [31:0] outImm;
  logic [31:0] outTgt;
  logic        inReady64;
  logic        outValid64;
  logic [63:0] outImm64;
  logic [63:0] outTgt64;

  vec_t vecs[NVEC];
  exp_t sbQ[$];
  exp_t curExp;
  int   compared;
  int   mismatched;

  imm_gen_pipe #(.XLEN(32), .SEL_WIDTH(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(inValid), .in_ready_o(inReady),
    .instruction_i(instr), .pc_i(pc), .select_i(sel), .flush_i(flush),
    .out_valid_o(outValid), .out_ready_i(outReady), .out_o(outImm),
    .target_o(outTgt)
  );

  // Wide instance sharing the handshake, so its occupancy tracks dut.
  imm_gen_pipe #(.XLEN(64), .SEL_WIDTH(3)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(inValid), .in_ready_o(inReady64),
    .instruction_i(instr), .pc_i(pc64), .select_i(sel), .flush_i(flush),
    .out_valid_o(outValid64), .out_ready_i(outReady), .out_o(outImm64),
    .target_o(outTgt64)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic valid);
    instr      = v.instr;
    sel        = v.sel;
    pc         = v.pc;
    pc64       = {32'd0, v.pc};
    inValid    = valid;
    curExp.imm = v.expImm;
    curExp.tgt = v.expTgt;
  endtask

  // Called one time unit after a rising edge with inputs already set:
  // checks the handshake against the queue occupancy, scores any transfer,
  // records any accept, then advances one clock.
  task automatic stepCycle();
    exp_t e;
    logic readyModel;
    readyModel = (sbQ.size() < 2);
    checkOutput("in_ready", {63'd0, inReady}, {63'd0, readyModel});
    checkOutput("out_valid", {63'd0, outValid}, {63'd0, sbQ.size() > 0});
    if (sbQ.size() > 0 && outReady) begin
      e = sbQ.pop_front();
      checkOutput("out_imm", {32'd0, outImm}, {32'd0, e.imm});
      checkOutput("out_tgt", {32'd0, outTgt}, {32'd0, e.tgt});
    end
    if (flush) sbQ.delete();
    else if (inValid && readyModel) sbQ.push_back(curExp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int g = 0; g < 8 && sbQ.size() > 0; g++) stepCycle();
    stepCycle();
  endtask

  initial begin
    logic accepted;
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    inValid    = 1'b0;
    flush      = 1'b0;
    outReady   = 1'b0;
    instr      = 32'd0;
    sel        = 3'd0;
    pc         = 32'd0;
    pc64       = 64'd0;
    curExp     = '{imm: 32'd0, tgt: 32'd0};

    vecs[0] = '{32'h12345037, 3'd0, 32'h00000000, 32'h12345000, 32'h12345000};
    vecs[1] = '{32'hFFF00093, 3'd2, 32'h00000040, 32'hFFFFFFFF, 32'h0000003F};
    vecs[2] = '{32'hFE000EE3, 3'd3, 32'h00000100, 32'hFFFFFFFC, 32'h000000FC};
    vecs[3] = '{32'h0080006F, 3'd1, 32'hFFFFFFFC, 32'h00000008, 32'h00000004};
    vecs[4] = '{32'h01F09093, 3'd5, 32'h00000000, 32'h0000001F, 32'h0000001F};
    vecs[5] = '{32'h000F8073, 3'd6, 32'h00000010, 32'h0000001F, 32'h0000002F};
    vecs[6] = '{32'hFE112E23, 3'd4, 32'h00000200, 32'hFFFFFFFC, 32'h000001FC};
    vecs[7] = '{32'h12345037, 3'd7, 32'h00000080, 32'h00000000, 32'h00000080};
    vecs[8] = '{32'h7FF00093, 3'd2, 32'h00001000, 32'h000007FF, 32'h000017FF};
    vecs[9] = '{32'h80000037, 3'd0, 32'h80000000, 32'h80000000, 32'h00000000};

    // Reset state, with inputs active to show they are ignored.
    applyStimulus(vecs[0], 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {63'd0, outValid}, 64'd0);
    checkOutput("rst_out", {32'd0, outImm}, 64'd0);
    checkOutput("rst_target", {32'd0, outTgt}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, inReady}, 64'd1);
    rst_n   = 1'b1;
    inValid = 1'b0;

    // Pass 1: back-to-back with the sink always ready.
    outReady = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], 1'b1);
      stepCycle();
    end
    drain();

    // Pass 2: random sink backpressure, each vector held until accepted.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], 1'b1);
      accepted = 1'b0;
      for (int g = 0; g < 50 && !accepted; g++) begin
        outReady = 1'($urandom_range(0, 1));
        accepted = (sbQ.size() < 2);
        stepCycle();
      end
      if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    end
    drain();

    // Backpressure: A to main, B to skid, C held upstream.
    outReady = 1'b0;
    applyStimulus(vecs[0], 1'b1); stepCycle();
    applyStimulus(vecs[1], 1'b1); stepCycle();
    applyStimulus(vecs[2], 1'b1);
    checkOutput("bp_full_in_ready", {63'd0, inReady}, 64'd0);
    stepCycle();
    checkOutput("bp_hold_a", {32'd0, outImm}, {32'd0, vecs[0].expImm});
    outReady = 1'b1;
    stepCycle();
    checkOutput("bp_ready_after_a", {63'd0, inReady}, 64'd1);
    stepCycle();
    inValid = 1'b0;
    stepCycle();
    stepCycle();

    // Flush while FULL with a new input offered the same cycle.
    outReady = 1'b0;
    applyStimulus(vecs[3], 1'b1); stepCycle();
    applyStimulus(vecs[4], 1'b1); stepCycle();
    applyStimulus(vecs[5], 1'b1);
    flush = 1'b1;
    stepCycle();
    flush   = 1'b0;
    inValid = 1'b0;
    checkOutput("flush_out_valid", {63'd0, outValid}, 64'd0);
    checkOutput("flush_in_ready", {63'd0, inReady}, 64'd1);
    outReady = 1'b1;
    repeat (2) stepCycle();

    // Asynchronous reset while FULL: outputs clear before the next edge.
    outReady = 1'b0;
    applyStimulus(vecs[6], 1'b1); stepCycle();
    applyStimulus(vecs[7], 1'b1); stepCycle();
    inValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", {63'd0, outValid}, 64'd0);
    checkOutput("async_rst_out", {32'd0, outImm}, 64'd0);
    checkOutput("async_rst_target", {32'd0, outTgt}, 64'd0);
    checkOutput("async_rst_in_ready", {63'd0, inReady}, 64'd1);
    checkOutput("async_rst_out64", outImm64, 64'd0);
    sbQ.delete();
    applyStimulus(vecs[8], 1'b1);
    @(posedge clk);
    #1;
    checkOutput("rst_ignore_input", {63'd0, outValid}, 64'd0);
    rst_n = 1'b1;

    // After release: SHAMT, then the wide instance's extension cases.
    outReady = 1'b1;
    applyStimulus(vecs[4], 1'b1);
    stepCycle();
    checkOutput("shamt_after_rst", {32'd0, outImm}, 64'h1F);
    checkOutput("shamt64", outImm64, 64'h1F);
    applyStimulus(vecs[1], 1'b1);
    stepCycle();
    checkOutput("i64_out", outImm64, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("i64_target", outTgt64, 64'h3F);
    applyStimulus('{32'h03F09093, 3'd5, 32'h0, 32'h1F, 32'h1F}, 1'b1);
    stepCycle();
    checkOutput("shamt64_bit25", outImm64, 64'h3F);
    applyStimulus(vecs[9], 1'b1);
    pc64 = 64'd0;
    stepCycle();
    checkOutput("u64_sign", outImm64, 64'hFFFF_FFFF_8000_0000);
    checkOutput("u64_target", outTgt64, 64'hFFFF_FFFF_8000_0000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
